// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle MULT/DIV sequencer: opcodes, controller
// states and the datapath operating mode.
package alu_muldiv_seq_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_MULT = 5'd12;
  localparam logic [4:0] ALU_DIV  = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_BAD = 2'd2,
    MD_DZ  = 2'd3
  } mode_e;

endpackage

// File: rtl/alu_muldiv_dp.sv
// Datapath for the MULT/DIV sequencer: operand magnitudes, shift-add / restoring
// iteration over a shared 2*OPR_L accumulator, and the final sign fix-up.
module alu_muldiv_dp
  import alu_muldiv_seq_pkg::*;
#(
  parameter int OPR_L = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  mode_e            mode_i,
  input  logic             sgn_i,
  input  logic [OPR_L-1:0] a_i,
  input  logic [OPR_L-1:0] b_i,
  input  logic             step_i,
  input  logic             fix_i,
  output logic [OPR_L-1:0] hi_o,
  output logic [OPR_L-1:0] lo_o
);

  localparam int W = OPR_L;

  mode_e          mode_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   mcand_q, opb_q, hi_q, lo_q;
  logic           neg_q, nega_q;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, rem_sh;
  logic [W+1:0]   div_diff;
  logic           div_keep;
  logic [2*W-1:0] acc_step, prod;
  logic [W-1:0]   quot, rem, hi_fix, lo_fix;

  always_comb begin
    a_neg = sgn_i & a_i[W-1];
    b_neg = sgn_i & b_i[W-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // In DIV mode the accumulator holds {remainder, quotient}; the remainder is
  // widened by one bit so the left shift cannot lose its top bit.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (opb_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = acc_q[2*W-1:W-1];
    div_diff = {1'b0, rem_sh} - {2'b00, opb_q};
    div_keep = ~div_diff[W+1];
    if (mode_q == MD_MUL) begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end else begin
      acc_step = {(div_keep ? div_diff[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], div_keep};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = acc_q[W-1:0];
    rem  = acc_q[2*W-1:W];
    case (mode_q)
      MD_MUL: begin
        hi_fix = prod[2*W-1:W];
        lo_fix = prod[W-1:0];
      end
      MD_DIV: begin
        hi_fix = nega_q ? -rem : rem;
        lo_fix = neg_q ? -quot : quot;
      end
      default: begin
        hi_fix = acc_q[2*W-1:W];
        lo_fix = acc_q[W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MD_MUL;
      acc_q   <= '0;
      mcand_q <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (load_i) begin
      mode_q  <= mode_i;
      mcand_q <= a_mag;
      opb_q   <= b_mag;
      neg_q   <= a_neg ^ b_neg;
      nega_q  <= a_neg;
      case (mode_i)
        MD_DIV:  acc_q <= {{W{1'b0}}, a_mag};
        MD_DZ:   acc_q <= {a_i, {W{1'b1}}};
        default: acc_q <= '0;
      endcase
    end else if (step_i) begin
      acc_q <= acc_step;
      if (mode_q == MD_MUL) opb_q <= opb_q >> 1;
    end else if (fix_i) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer beside the EX-stage ALU: request/response
// handshake, iteration counter and controller FSM around alu_muldiv_dp.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int OPR_L   = 32,
  parameter int ALUOP_L = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ALUOP_L-1:0] op,
  input  logic               sgn,
  input  logic [OPR_L-1:0]   a,
  input  logic [OPR_L-1:0]   b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [OPR_L-1:0]   hi,
  output logic [OPR_L-1:0]   lo,
  output logic               div_zero,
  output logic               bad_op,
  output state_e             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payloads are only sampled then.
  localparam int CNT_W = $clog2(OPR_L);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             resp_valid_q, div_zero_q, bad_op_q;
  logic             accept;
  mode_e            mode_in;

  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  always_comb begin
    if (op == ALUOP_L'(ALU_MULT))     mode_in = MD_MUL;
    else if (op != ALUOP_L'(ALU_DIV)) mode_in = MD_BAD;
    else if (b == '0)                 mode_in = MD_DZ;
    else                              mode_in = MD_DIV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      div_zero_q   <= 1'b0;
      bad_op_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          count_q    <= '0;
          div_zero_q <= 1'b0;
          bad_op_q   <= 1'b0;
          state_q    <= (mode_in == MD_BAD || mode_in == MD_DZ) ? ST_FIX : ST_CALC;
        end
        ST_CALC: begin
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(OPR_L - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          resp_valid_q <= 1'b1;
          div_zero_q   <= (u_dp.mode_q == MD_DZ);
          bad_op_q     <= (u_dp.mode_q == MD_BAD);
          state_q      <= ST_DONE;
        end
        ST_DONE: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  alu_muldiv_dp #(.OPR_L(OPR_L)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .mode_i (mode_in),
    .sgn_i  (sgn),
    .a_i    (a),
    .b_i    (b),
    .step_i (state_q == ST_CALC),
    .fix_i  (state_q == ST_FIX),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  assign resp_valid  = resp_valid_q;
  assign div_zero    = div_zero_q;
  assign bad_op      = bad_op_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed corner cases plus randomized
// MULT/DIV traffic against an arithmetic reference model.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_ready, sgn, resp_valid, resp_ready;
  logic [4:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        div_zero, bad_op;
  state_e      dbg_state;

  int          n_checks, n_errors;
  logic [65:0] exp_q[$];

  alu_muldiv_seq #(.OPR_L(32), .ALUOP_L(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .op          (op),
    .sgn         (sgn),
    .a           (a),
    .b           (b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .hi          (hi),
    .lo          (lo),
    .div_zero    (div_zero),
    .bad_op      (bad_op),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result packed as {div_zero, bad_op, hi, lo}, computed with plain arithmetic.
  function automatic logic [65:0] model(input logic [4:0] op_v, input logic sgn_v,
                                        input logic [31:0] a_v, input logic [31:0] b_v);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    if (op_v != ALU_MULT && op_v != ALU_DIV) return {2'b01, 64'd0};
    if (op_v == ALU_DIV && b_v == 32'd0) return {2'b10, a_v, 32'hFFFF_FFFF};
    sa = sgn_v ? longint'($signed(a_v)) : longint'({32'd0, a_v});
    sb = sgn_v ? longint'($signed(b_v)) : longint'({32'd0, b_v});
    if (op_v == ALU_MULT) begin
      if (sgn_v) p = 64'(sa * sb);
      else       p = {32'd0, a_v} * {32'd0, b_v};
      return {2'b00, p};
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {2'b00, rv[31:0], qv[31:0]};
  endfunction

  task automatic run_op(input logic [4:0] op_v, input logic sgn_v,
                        input logic [31:0] a_v, input logic [31:0] b_v, input int hold);
    int          lat, exp_lat;
    logic [65:0] exp;
    exp_q.push_back(model(op_v, sgn_v, a_v, b_v));
    exp_lat = ((op_v != ALU_MULT && op_v != ALU_DIV) || (op_v == ALU_DIV && b_v == 0)) ? 1 : 33;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; op = op_v; sgn = sgn_v; a = a_v; b = b_v;
    @(posedge clk);
    #1;
    req_valid = 0; a = $urandom; b = $urandom; sgn = $urandom_range(0, 1);
    op = 5'($urandom);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      if (lat > 0) chk("req_ready_busy", req_ready, 0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    exp = exp_q.pop_front();
    chk("result", {div_zero, bad_op, hi, lo}, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", {div_zero, bad_op, hi, lo}, exp);
      chk("hold_valid", {resp_valid, req_ready}, 2'b10);
    end
    resp_ready = 1;
    @(posedge clk);
    #1;
    resp_ready = 0;
    chk("after_hs", {resp_valid, req_ready}, 2'b01);
    chk("after_hs_keep", {div_zero, bad_op, hi, lo}, exp);
  endtask

  initial begin
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b;
    int          kind;
    n_checks = 0; n_errors = 0;
    rst = 1; req_valid = 0; resp_ready = 0; op = '0; sgn = 0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {req_ready, resp_valid, div_zero, bad_op, hi, lo}, 68'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst", {req_ready, resp_valid, div_zero, bad_op, hi, lo}, {1'b1, 67'd0});

    run_op(ALU_MULT, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(ALU_MULT, 1, 32'hFFFF_FFFD, 32'd7, 1);
    run_op(ALU_MULT, 0, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(ALU_DIV, 1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(ALU_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(ALU_DIV, 0, 32'd5, 32'd0, 0);
    run_op(ALU_ADD, 0, 32'd9, 32'd3, 0);
    run_op(ALU_MULT, 1, 32'h1234_5678, 32'h9ABC_DEF0, 5);

    // Reset in the middle of a MULT: nothing may come back from it.
    @(negedge clk);
    req_valid = 1; op = ALU_MULT; sgn = 0; a = 32'd1000; b = 32'd77;
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mid_rst", {req_ready, resp_valid, div_zero, bad_op, hi, lo}, 68'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {req_ready, resp_valid, div_zero, bad_op, hi, lo}, 68'd0);
    @(negedge clk);
    rst = 0;
    run_op(ALU_DIV, 0, 32'd100, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      r_a  = (kind == 9) ? 32'h8000_0000 : $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      case (kind)
        0:       begin r_op = 5'($urandom_range(0, 11)); end
        1:       begin r_op = ALU_DIV; r_b = 32'd0; end
        2, 3, 4: begin r_op = ALU_MULT; end
        default: begin r_op = ALU_DIV; end
      endcase
      run_op(r_op, 1'($urandom_range(0, 1)), r_a, r_b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
